sqrt_pipe_arbiter: RTL and testbench

//  Shares one fixed-latency square-root pipeline (range reduction -> approx ->

---
 rtl/sqrt_pipe_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sqrt_pipe_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_pipe_arbiter.sv
// Round-robin front end that shares one fixed-latency sqrt pipeline between NREQ requesters,
// with per-requester credit limits, a tag delay line for result routing and a drain FSM.
module sqrt_pipe_arbiter #(
    parameter int NREQ     = 4,
    parameter int XW       = 32,
    parameter int PIPE_LAT = 6,
    parameter int MAX_OUT  = 2
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic [NREQ-1:0]      iReq_valid,
    input  logic [NREQ*XW-1:0]   iReq_x,
    output logic [NREQ-1:0]      oReq_ready,
    output logic                 oPipe_valid,
    output logic [XW-1:0]        oPipe_x,
    input  logic [16:0]          iPipe_f,
    output logic [NREQ-1:0]      oRsp_valid,
    output logic [16:0]          oRsp_f,
    input  logic                 iDrain,
    output logic                 oDrained,
    output logic                 oBusy
);

    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(NREQ * MAX_OUT + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       rr_q, rr_d;
    logic [CW-1:0]       cnt_q [NREQ];
    logic [CW-1:0]       cnt_d [NREQ];
    logic [NREQ-1:0]     elig;
    logic                grant_vld;
    logic [TW-1:0]       grant_idx;
    logic                can_issue;
    logic                hs;
    logic [SW-1:0]       total;

    logic                pipe_vld_q;
    logic [XW-1:0]       pipe_x_q, pipe_x_d;
    logic [NREQ-1:0]     rsp_vld_q, rsp_vld_d;
    logic [16:0]         rsp_f_q, rsp_f_d;

    logic                tag_vld_q [PIPE_LAT+1];
    logic [TW-1:0]       tag_id_q  [PIPE_LAT+1];
    logic                tag_out_vld;
    logic [TW-1:0]       tag_out_id;

    function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] base, input int off);
        logic [TW:0] s;
        s = {1'b0, base} + (TW+1)'(off);
        if (s >= (TW+1)'(NREQ)) begin
            s = s - (TW+1)'(NREQ);
        end
        return s[TW-1:0];
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [TW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            elig[k] = iReq_valid[k] && (cnt_q[k] < CW'(MAX_OUT));
        end
    end

    // Scan starts at rr_q so the most recently served requester is visited last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_vld && elig[wrap_add(rr_q, i)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(rr_q, i);
            end
        end
    end

    assign can_issue  = (state_q == ST_RUN) && !iDrain && !iRst;
    assign hs         = can_issue && grant_vld;
    assign oReq_ready = hs ? onehot(grant_idx) : '0;

    always_comb begin
        rr_d     = hs ? wrap_add(grant_idx, 1) : rr_q;
        pipe_x_d = hs ? iReq_x[int'(grant_idx)*XW +: XW] : pipe_x_q;
    end

    assign tag_out_vld = tag_vld_q[PIPE_LAT];
    assign tag_out_id  = tag_id_q[PIPE_LAT];

    always_comb begin
        rsp_vld_d = tag_out_vld ? onehot(tag_out_id) : '0;
        rsp_f_d   = tag_out_vld ? iPipe_f : rsp_f_q;
    end

    // A grant and a returning tag for the same requester cancel out.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            cnt_d[k] = cnt_q[k];
            if ((hs && (grant_idx == TW'(k))) && !(tag_out_vld && (tag_out_id == TW'(k)))) begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end else if (!(hs && (grant_idx == TW'(k))) && (tag_out_vld && (tag_out_id == TW'(k)))) begin
                cnt_d[k] = cnt_q[k] - CW'(1);
            end
        end
    end

    always_comb begin
        total = '0;
        for (int k = 0; k < NREQ; k++) begin
            total = total + SW'(cnt_q[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (iDrain) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((total == '0) && (rsp_vld_q == '0)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!iDrain) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_RUN;
            rr_q       <= '0;
            pipe_vld_q <= 1'b0;
            pipe_x_q   <= '0;
            rsp_vld_q  <= '0;
            rsp_f_q    <= '0;
            for (int k = 0; k < NREQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            pipe_vld_q <= hs;
            pipe_x_q   <= pipe_x_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_f_q    <= rsp_f_d;
            for (int k = 0; k < NREQ; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Stage 0 loads with oPipe_valid; stage PIPE_LAT lines up with iPipe_f.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int s = 0; s <= PIPE_LAT; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_id_q[s]  <= '0;
            end
        end else begin
            tag_vld_q[0] <= hs;
            tag_id_q[0]  <= grant_idx;
            for (int s = 1; s <= PIPE_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    assign oPipe_valid = pipe_vld_q;
    assign oPipe_x     = pipe_x_q;
    assign oRsp_valid  = rsp_vld_q;
    assign oRsp_f      = rsp_f_q;
    assign oDrained    = (state_q == ST_HOLD);
    assign oBusy       = (total != '0);

endmodule

// File: tb/tb_sqrt_pipe_arbiter.sv
// Bench for sqrt_pipe_arbiter: emulates the sqrt pipeline and checks every cycle against a
// time-stamped in-flight queue model, plus directed literal checks for the key scenarios.
module tb_sqrt_pipe_arbiter;

    localparam int NREQ     = 4;
    localparam int XW       = 32;
    localparam int PIPE_LAT = 6;
    localparam int MAX_OUT  = 2;

    logic                clk = 1'b0;
    logic                iRst;
    logic [NREQ-1:0]     iReq_valid;
    logic [NREQ*XW-1:0]  iReq_x;
    logic [NREQ-1:0]     oReq_ready;
    logic                oPipe_valid;
    logic [XW-1:0]       oPipe_x;
    logic [16:0]         iPipe_f;
    logic [NREQ-1:0]     oRsp_valid;
    logic [16:0]         oRsp_f;
    logic                iDrain;
    logic                oDrained;
    logic                oBusy;

    always #5 clk = ~clk;

    sqrt_pipe_arbiter #(
        .NREQ(NREQ), .XW(XW), .PIPE_LAT(PIPE_LAT), .MAX_OUT(MAX_OUT)
    ) dut (
        .iClk(clk), .iRst(iRst), .iReq_valid(iReq_valid), .iReq_x(iReq_x),
        .oReq_ready(oReq_ready), .oPipe_valid(oPipe_valid), .oPipe_x(oPipe_x),
        .iPipe_f(iPipe_f), .oRsp_valid(oRsp_valid), .oRsp_f(oRsp_f),
        .iDrain(iDrain), .oDrained(oDrained), .oBusy(oBusy)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    function automatic logic [16:0] isqrt(input logic [31:0] x);
        longint r, t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        return 17'(r);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sqrt pipeline emulation: operand seen on oPipe in cycle c returns on iPipe_f in c+PIPE_LAT.
    bit          env_v [64];
    logic [31:0] env_x [64];

    initial begin
        iPipe_f = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc >= PIPE_LAT && env_v[(cyc - PIPE_LAT) % 64])
                iPipe_f = isqrt(env_x[(cyc - PIPE_LAT) % 64]);
            else
                iPipe_f = 17'h10000 | 17'(cyc * 7);
        end
    end

    // Reference model: list of in-flight operands stamped with their handshake cycle.
    typedef struct {
        int          req;
        int          t;
        logic [31:0] x;
    } ent_t;

    ent_t            q[$];
    int              m_rr = 0;
    int              m_st = 0;
    bit              model_ok = 0;
    logic            e_pv = 1'b0;
    logic [31:0]     e_px = '0;
    logic [NREQ-1:0] e_rv = '0;
    logic [16:0]     e_rf = '0;

    initial begin : compare
        int              cnt [NREQ];
        int              g;
        int              k;
        int              total;
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] prev_rv;
        forever begin
            @(negedge clk);
            env_v[cyc % 64] = (oPipe_valid === 1'b1);
            env_x[cyc % 64] = oPipe_x;

            for (int j = 0; j < NREQ; j++) cnt[j] = 0;
            foreach (q[i]) cnt[q[i].req]++;
            total = q.size();

            g  = -1;
            er = '0;
            if (!iRst && m_st == 0 && !iDrain) begin
                for (int i = 0; i < NREQ; i++) begin
                    k = (m_rr + i) % NREQ;
                    if (g < 0 && iReq_valid[k] && cnt[k] < MAX_OUT) g = k;
                end
            end
            if (g >= 0) er[g] = 1'b1;

            if (model_ok) begin
                chk("ready",      64'(oReq_ready),  64'(er));
                chk("pipe_valid", 64'(oPipe_valid), 64'(e_pv));
                chk("pipe_x",     64'(oPipe_x),     64'(e_px));
                chk("rsp_valid",  64'(oRsp_valid),  64'(e_rv));
                chk("rsp_f",      64'(oRsp_f),      64'(e_rf));
                chk("busy",       64'(oBusy),       64'(total != 0));
                chk("drained",    64'(oDrained),    64'(m_st == 2));
            end

            if (iRst) begin
                q.delete();
                m_rr     = 0;
                m_st     = 0;
                e_pv     = 1'b0;
                e_px     = '0;
                e_rv     = '0;
                e_rf     = '0;
                model_ok = 1;
            end else if (model_ok) begin
                prev_rv = e_rv;
                if (q.size() > 0 && q[0].t + PIPE_LAT + 1 == cyc) begin
                    e_rv = NREQ'(1) << q[0].req;
                    e_rf = isqrt(q[0].x);
                    void'(q.pop_front());
                end else begin
                    e_rv = '0;
                end
                e_pv = (g >= 0);
                if (g >= 0) begin
                    e_px = iReq_x[g*XW +: XW];
                    q.push_back('{g, cyc, iReq_x[g*XW +: XW]});
                    m_rr = (g + 1) % NREQ;
                end
                case (m_st)
                    0: if (iDrain) m_st = 1;
                    1: if (total == 0 && prev_rv == '0) m_st = 2;
                    2: if (!iDrain) m_st = 0;
                    default: m_st = 0;
                endcase
            end
        end
    end

    logic [3:0] rd  [12];
    logic [3:0] t3e [10];
    int         n;

    initial begin
        iRst       = 1'b1;
        iReq_valid = '0;
        iReq_x     = '0;
        iDrain     = 1'b0;
        step();
        step();
        iRst = 1'b0;
        @(negedge clk);
        chk("rst_ready",   64'(oReq_ready),  64'h0);
        chk("rst_pvalid",  64'(oPipe_valid), 64'h0);
        chk("rst_px",      64'(oPipe_x),     64'h0);
        chk("rst_rvalid",  64'(oRsp_valid),  64'h0);
        chk("rst_rf",      64'(oRsp_f),      64'h0);
        chk("rst_drained", 64'(oDrained),    64'h0);
        chk("rst_busy",    64'(oBusy),       64'h0);

        // T1: single operand, latency pin
        step();
        iReq_x[31:0] = 32'h0001_0000;
        iReq_valid   = 4'b0001;
        @(negedge clk);
        chk("t1_ready", 64'(oReq_ready), 64'h1);
        step();
        iReq_valid = '0;
        @(negedge clk);
        chk("t1_pvalid", 64'(oPipe_valid), 64'h1);
        chk("t1_px",     64'(oPipe_x),     64'h0001_0000);
        repeat (6) @(negedge clk);
        chk("t1_rsp_early", 64'(oRsp_valid), 64'h0);
        @(negedge clk);
        chk("t1_rsp_valid", 64'(oRsp_valid), 64'h1);
        chk("t1_rsp_f",     64'(oRsp_f),     64'h100);
        repeat (4) step();

        // T2: all requesters continuously valid; rotation starts at 1 after T1
        iReq_x     = {32'hFFFF_FFFF, 32'h0000_0019, 32'h00F4_2400, 32'h0000_0000};
        iReq_valid = 4'hF;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rd[i] = oReq_ready;
            step();
        end
        iReq_valid = '0;
        for (int i = 0; i < 12; i++)
            chk("t2_grant", 64'(rd[i]), 64'(4'b0001 << ((i + 1) % 4)));
        repeat (14) step();

        // T3: req2 alone hits its credit limit
        iReq_x[64 +: 32] = 32'd144;
        iReq_valid       = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd[i] = oReq_ready;
            step();
        end
        iReq_valid = '0;
        t3e = '{4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        for (int i = 0; i < 10; i++) chk("t3_ready", 64'(rd[i]), 64'(t3e[i]));
        repeat (14) step();

        // T6: grant to 1 in the cycle its earlier tag returns
        iReq_x[32 +: 32] = 32'd10000;
        iReq_valid       = 4'b0010;
        @(negedge clk);
        chk("t6_first", 64'(oReq_ready), 64'h2);
        step();
        iReq_valid = '0;
        repeat (6) step();
        iReq_valid = 4'b0010;
        @(negedge clk);
        chk("t6_same_cycle", 64'(oReq_ready), 64'h2);
        step();
        @(negedge clk);
        chk("t6_next", 64'(oReq_ready), 64'h2);
        chk("t6_rsp",  64'(oRsp_valid), 64'h2);
        chk("t6_f",    64'(oRsp_f),     64'd100);
        step();
        iReq_valid = '0;
        repeat (14) step();

        // T4: three in flight, then drain
        iReq_x     = {32'd81, 32'd0, 32'd49, 32'd400};
        iReq_valid = 4'b1011;
        repeat (3) step();
        iDrain = 1'b1;
        @(negedge clk);
        chk("t4_ready_drain", 64'(oReq_ready), 64'h0);
        n = 0;
        while (oDrained !== 1'b1 && n < 40) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("t4_drain_done", 64'(oDrained), 64'h1);
        chk("t4_busy",       64'(oBusy),    64'h0);
        step();
        iDrain     = 1'b0;
        iReq_valid = 4'b0001;
        @(negedge clk);
        chk("t4_hold_ready", 64'(oReq_ready), 64'h0);
        chk("t4_hold_drn",   64'(oDrained),   64'h1);
        step();
        @(negedge clk);
        chk("t4_resume",     64'(oReq_ready), 64'h1);
        chk("t4_resume_drn", 64'(oDrained),   64'h0);
        step();
        iReq_valid = '0;
        repeat (14) step();

        // Drain with nothing in flight, iDrain dropped while draining
        iDrain = 1'b1;
        @(negedge clk);
        chk("idle_drn0", 64'(oDrained), 64'h0);
        step();
        iDrain     = 1'b0;
        iReq_valid = 4'b0100;
        @(negedge clk);
        chk("idle_drn1", 64'(oDrained),   64'h0);
        chk("idle_rdy1", 64'(oReq_ready), 64'h0);
        step();
        @(negedge clk);
        chk("idle_drn2", 64'(oDrained),   64'h1);
        chk("idle_rdy2", 64'(oReq_ready), 64'h0);
        step();
        @(negedge clk);
        chk("idle_drn3", 64'(oDrained),   64'h0);
        chk("idle_rdy3", 64'(oReq_ready), 64'h4);
        step();
        iReq_valid = '0;
        repeat (14) step();

        // T5: reset with two operations in flight
        iReq_x     = {32'd1024, 32'd900, 32'd4, 32'd1};
        iReq_valid = 4'b1100;
        repeat (2) step();
        iReq_valid = '0;
        repeat (2) step();
        iRst       = 1'b1;
        iReq_valid = 4'hF;
        @(negedge clk);
        chk("t5_rst_ready", 64'(oReq_ready), 64'h0);
        step();
        iRst       = 1'b0;
        iReq_valid = '0;
        @(negedge clk);
        chk("t5_pvalid",  64'(oPipe_valid), 64'h0);
        chk("t5_px",      64'(oPipe_x),     64'h0);
        chk("t5_rvalid",  64'(oRsp_valid),  64'h0);
        chk("t5_rf",      64'(oRsp_f),      64'h0);
        chk("t5_busy",    64'(oBusy),       64'h0);
        chk("t5_drained", 64'(oDrained),    64'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            chk("t5_no_rsp", 64'(oRsp_valid), 64'h0);
        end
        step();
        iReq_valid = 4'hF;
        @(negedge clk);
        chk("t5_rr0", 64'(oReq_ready), 64'h1);
        step();
        iReq_valid = '0;
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
